neuron_layer_sched: RTL

- Sequencer that time-shares one scalar-product + LUT activation datapath across the NUM_NEURONS neurons of a layer.
- Accepts one 2-element input vector (x1, x2) via valid/ready and holds a per-neuron weight pair (w1, w2) in an internal register file.
- For each neuron in index order, drives the shared datapath operands, waits the datapath latency, captures the activated result and streams it out via valid/ready.
- Sits between the input/weight-load logic and the existing scalar-product/LUT datapath, which remains external.

---
 rtl/neuron_layer_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/neuron_layer_sched.sv
// Layer sequencer: walks each neuron of a layer through one shared
// scalar-product + LUT datapath and streams the activated results out in index order.
module neuron_layer_sched #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SP_LATENCY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x1,
    input  logic [DATA_W-1:0] in_x2,
    input  logic              wt_we,
    input  logic [ADDR_W-1:0] wt_addr,
    input  logic [DATA_W-1:0] wt_w1,
    input  logic [DATA_W-1:0] wt_w2,
    output logic              wt_err,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_w1,
    output logic [DATA_W-1:0] dp_b,
    output logic [DATA_W-1:0] dp_w2,
    output logic              dp_issue,
    input  logic [DATA_W-1:0] dp_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dp_a_q, dp_a_d, dp_b_q, dp_b_d;
    logic [DATA_W-1:0]   dp_w1_q, dp_w1_d, dp_w2_q, dp_w2_d;
    logic                dp_issue_q, dp_issue_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
    logic                out_last_q, out_last_d;
    logic                wt_err_q, wt_err_d;
    logic                wt_commit;

    logic [DATA_W-1:0]   w1_mem [DEPTH];
    logic [DATA_W-1:0]   w2_mem [DEPTH];

    logic [ADDR_W-1:0]   next_idx;
    logic                idx_is_last;
    logic                addr_ok;

    assign next_idx    = idx_q + ADDR_W'(1);
    assign idx_is_last = ({1'b0, idx_q} == (ADDR_W+1)'(NUM_NEURONS - 1));
    assign addr_ok     = ({1'b0, wt_addr} < (ADDR_W+1)'(NUM_NEURONS));

    // A weight write always takes priority over a vector handshake in the same cycle.
    assign in_ready = (state_q == IDLE) && !wt_we && !rst;
    assign busy     = (state_q != IDLE);

    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_w1     = dp_w1_q;
    assign dp_w2     = dp_w2_q;
    assign dp_issue  = dp_issue_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign wt_err    = wt_err_q;

    // Weight register file; intentionally survives reset.
    always_ff @(posedge clk) begin
        if (wt_commit) begin
            w1_mem[wt_addr] <= wt_w1;
            w2_mem[wt_addr] <= wt_w2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            dp_w1_q     <= '0;
            dp_w2_q     <= '0;
            dp_issue_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            wt_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            dp_w1_q     <= dp_w1_d;
            dp_w2_q     <= dp_w2_d;
            dp_issue_q  <= dp_issue_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            wt_err_q    <= wt_err_d;
        end
    end

    // Next-state and registered-output logic; dp_* only change when a new neuron is loaded.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        dp_w1_d     = dp_w1_q;
        dp_w2_d     = dp_w2_q;
        dp_issue_d  = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        wt_err_d    = 1'b0;
        wt_commit   = 1'b0;

        if (wt_we) begin
            if ((state_q == IDLE) && addr_ok && !rst) begin
                wt_commit = 1'b1;
            end else begin
                wt_err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    dp_a_d     = in_x1;
                    dp_b_d     = in_x2;
                    dp_w1_d    = w1_mem[0];
                    dp_w2_d    = w2_mem[0];
                    idx_d      = '0;
                    dp_issue_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (SP_LATENCY == 0) begin
                    out_data_d  = dp_result;
                    out_idx_d   = idx_q;
                    out_last_d  = idx_is_last;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(SP_LATENCY)) begin
                    out_data_d  = dp_result;
                    out_idx_d   = idx_q;
                    out_last_d  = idx_is_last;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d      = next_idx;
                        dp_w1_d    = w1_mem[next_idx];
                        dp_w2_d    = w2_mem[next_idx];
                        dp_issue_d = 1'b1;
                        state_d    = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
